// File: rtl/stoch_frame_serializer_if.sv
// Word handshake between a probability-word source and the frame serializer.
// The source drives data and valid, the serializer answers with ready.
interface stoch_frame_serializer_if #(
   parameter int DATA_W = 9
);
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/stoch_frame_serializer.sv
// Serializes probability words LSB first with a zero pad bit.
// A programmable idle gap follows each frame.
module stoch_frame_serializer #(
   parameter int DATA_W     = 9,
   parameter int GAP_CYCLES = 131068
) (
   input  logic                    clk,
   input  logic                    rst_n,
   stoch_frame_serializer_if.slave s_if,
   output logic                    serial_out,
   output logic                    frame_sync,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W);
   localparam logic [16:0] GAP_LAST =
      (GAP_CYCLES == 0) ? 17'd0 : 17'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PAD,
      GAP
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] sr_q;
   logic [CW-1:0]     bit_cnt_q;
   logic [16:0]       gap_cnt_q;
   logic              serial_q;
   logic              sync_q;
   logic              done_q;
   logic              busy_q;
   logic              ovr_q;

   assign s_if.data_ready = (state_q == IDLE);
   assign serial_out      = serial_q;
   assign frame_sync      = sync_q;
   assign frame_done      = done_q;
   assign busy            = busy_q;
   assign overrun         = ovr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         serial_q  <= 1'b0;
         sync_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync_q <= 1'b0;
         done_q <= 1'b0;
         if (s_if.data_valid && state_q != IDLE) begin
            ovr_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               // Bit 0 leaves on the capture edge so it lands in cycle N+1
               if (s_if.data_valid) begin
                  state_q   <= SHIFT;
                  serial_q  <= s_if.data_in[0];
                  sr_q      <= s_if.data_in >> 1;
                  bit_cnt_q <= CW'(1);
                  sync_q    <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_cnt_q == BIT_LAST) begin
                  state_q   <= PAD;
                  serial_q  <= 1'b0;
                  bit_cnt_q <= '0;
                  done_q    <= 1'b1;
               end else begin
                  serial_q  <= sr_q[0];
                  sr_q      <= sr_q >> 1;
                  bit_cnt_q <= bit_cnt_q + CW'(1);
               end
            end
            PAD: begin
               gap_cnt_q <= '0;
               if (GAP_CYCLES == 0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  gap_cnt_q <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 17'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stoch_frame_serializer.sv
// Directed bench: short-gap, zero-gap and default-gap serializers
// checked against hand-computed frame timing and word values.
module tb_stoch_frame_serializer;

   logic       clk = 1'b0;
   logic       rst [3];
   logic       vld [3];
   logic [8:0] din [3];
   logic       ser [3];
   logic       sync [3];
   logic       done [3];
   logic       rdy [3];
   logic       bsy [3];
   logic       ovr [3];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stoch_frame_serializer_if #(.DATA_W(9)) if_a ();
   stoch_frame_serializer_if #(.DATA_W(9)) if_b ();
   stoch_frame_serializer_if #(.DATA_W(9)) if_c ();

   assign if_a.data_in    = din[0];
   assign if_a.data_valid = vld[0];
   assign if_b.data_in    = din[1];
   assign if_b.data_valid = vld[1];
   assign if_c.data_in    = din[2];
   assign if_c.data_valid = vld[2];
   assign rdy[0] = if_a.data_ready;
   assign rdy[1] = if_b.data_ready;
   assign rdy[2] = if_c.data_ready;

   stoch_frame_serializer #(.DATA_W(9), .GAP_CYCLES(4)) u_a (
      .clk        (clk),
      .rst_n      (rst[0]),
      .s_if       (if_a),
      .serial_out (ser[0]),
      .frame_sync (sync[0]),
      .busy       (bsy[0]),
      .frame_done (done[0]),
      .overrun    (ovr[0])
   );

   stoch_frame_serializer #(.DATA_W(9), .GAP_CYCLES(0)) u_b (
      .clk        (clk),
      .rst_n      (rst[1]),
      .s_if       (if_b),
      .serial_out (ser[1]),
      .frame_sync (sync[1]),
      .busy       (bsy[1]),
      .frame_done (done[1]),
      .overrun    (ovr[1])
   );

   stoch_frame_serializer u_c (
      .clk        (clk),
      .rst_n      (rst[2]),
      .s_if       (if_c),
      .serial_out (ser[2]),
      .frame_sync (sync[2]),
      .busy       (bsy[2]),
      .frame_done (done[2]),
      .overrun    (ovr[2])
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b0;
      vld[d] = 1'b0;
      repeat (2) @(negedge clk);
      rst[d] = 1'b1;
   endtask

   task automatic wait_sync(input int d, input int limit);
      int n = 0;
      while (!sync[d] && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("sync_seen", 32'(sync[d]), 32'd1);
   endtask

   // Bitstream-to-word receiver: call on the frame_sync cycle
   task automatic rx_word(input int d, output logic [8:0] w);
      w[0] = ser[d];
      for (int k = 1; k < 9; k++) begin
         @(negedge clk);
         w[k] = ser[d];
      end
   endtask

   logic [4:0] exp_s1 [15] = '{
      5'b11001, 5'b00001, 5'b10001, 5'b00001, 5'b00001,
      5'b10001, 5'b00001, 5'b10001, 5'b10001, 5'b00101,
      5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00010
   };
   logic [8:0] lb_vals [3] = '{9'd0, 9'd256, 9'd511};

   initial begin
      logic [8:0] w;
      int t1;
      int n;
      int nr;
      int ns;
      int first;
      logic acc;

      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0;
         vld[d] = 1'b1;
         din[d] = 9'h1FF;
      end
      repeat (2) @(negedge clk);
      check("rst_outs", 32'({ser[0], sync[0], done[0], bsy[0], ovr[0]}), 0);
      check("rst_rdy", 32'(rdy[0]), 32'd1);
      check("rst_vld_no_ovr", 32'(ovr[1]), 32'd0);
      for (int d = 0; d < 3; d++) begin
         vld[d] = 1'b0;
         rst[d] = 1'b1;
      end
      @(negedge clk);
      check("rdy_after_rel", 32'(rdy[0]), 32'd1);

      // Single frame, 9'h1A5, gap 4
      din[0] = 9'h1A5;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      din[0] = 9'h000;
      for (int k = 0; k < 15; k++) begin
         check($sformatf("s1_c%0d", k + 1),
               32'({ser[0], sync[0], done[0], rdy[0], bsy[0]}),
               32'(exp_s1[k]));
         @(negedge clk);
      end

      // Back-to-back, data changed after capture
      din[0] = 9'h000;
      vld[0] = 1'b1;
      @(negedge clk);
      wait_sync(0, 4);
      t1 = cyc;
      din[0] = 9'h1FF;
      rx_word(0, w);
      check("b2b_w0", 32'(w), 32'h000);
      @(negedge clk);
      wait_sync(0, 20);
      check("b2b_period", 32'(cyc - t1), 32'd15);
      rx_word(0, w);
      check("b2b_w1", 32'(w), 32'h1FF);
      vld[0] = 1'b0;
      check("b2b_ovr", 32'(ovr[0]), 32'd1);

      // Zero gap, valid held
      din[1] = 9'h0A5;
      vld[1] = 1'b1;
      @(negedge clk);
      wait_sync(1, 4);
      nr = 0;
      ns = 0;
      first = 0;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         if (rdy[1]) nr++;
         if (sync[1]) begin
            ns++;
            if (first == 0) first = i;
         end
      end
      vld[1] = 1'b0;
      check("zg_period", 32'(first), 32'd11);
      check("zg_syncs", 32'(ns), 32'd2);
      check("zg_rdy_cycles", 32'(nr), 32'd2);

      // Overrun during gap; valid in reset ignored
      rst[0] = 1'b0;
      vld[0] = 1'b1;
      repeat (2) @(negedge clk);
      vld[0] = 1'b0;
      rst[0] = 1'b1;
      @(negedge clk);
      check("ovr_rst_clr", 32'(ovr[0]), 32'd0);
      check("ovr_rst_rdy", 32'(rdy[0]), 32'd1);
      din[0] = 9'h155;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      n = 0;
      while (!done[0] && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("ovr_done_seen", 32'(done[0]), 32'd1);
      @(negedge clk);
      check("ovr_gap_rdy", 32'(rdy[0]), 32'd0);
      check("ovr_pre", 32'(ovr[0]), 32'd0);
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      check("ovr_set", 32'(ovr[0]), 32'd1);
      n = 0;
      while (!rdy[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ovr_rdy_back", 32'(rdy[0]), 32'd1);
      din[0] = 9'h0F0;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      wait_sync(0, 4);
      rx_word(0, w);
      check("ovr_next_word", 32'(w), 32'h0F0);
      check("ovr_sticky", 32'(ovr[0]), 32'd1);
      do_reset(0);
      check("ovr_cleared", 32'(ovr[0]), 32'd0);
      @(negedge clk);

      // Reset mid-frame at cycle N+5
      din[0] = 9'h1FF;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(bsy[0]), 32'd1);
      rst[0] = 1'b0;
      @(negedge clk);
      check("mid_abort", 32'({ser[0], bsy[0]}), 32'd0);
      rst[0] = 1'b1;
      @(negedge clk);
      check("mid_rdy", 32'(rdy[0]), 32'd1);
      acc = 1'b0;
      for (int i = 0; i < 12; i++) begin
         acc = acc | ser[0] | done[0];
         @(negedge clk);
      end
      check("mid_quiet", 32'(acc), 32'd0);

      // Loopback with default parameters
      for (int j = 0; j < 3; j++) begin
         do_reset(2);
         @(negedge clk);
         din[2] = lb_vals[j];
         vld[2] = 1'b1;
         @(negedge clk);
         vld[2] = 1'b0;
         wait_sync(2, 4);
         rx_word(2, w);
         check($sformatf("lb_%0d", j), 32'(w), 32'(lb_vals[j]));
         @(negedge clk);
         check($sformatf("lb_done_%0d", j), 32'(done[2]), 32'd1);
         if (j == 0) begin
            repeat (100) @(negedge clk);
            check("lb_long_gap", 32'({bsy[2], rdy[2]}), 32'b10);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stoch_frame_serializer.md
STOCH_FRAME_SERIALIZER -- requirements
Module: stoch_frame_serializer

Interface
REQ-001 Parameter: DATA_W, default 9, width of each probability word carried per frame.
REQ-002 Parameter: GAP_CYCLES, default 131068, number of idle cycles after each frame; legal range 0..131071.
REQ-003 Port: clk  input  1  single clock; all logic is on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: data_in  input  DATA_W  parallel probability word to transmit.
REQ-006 Port: data_valid  input  1  data_in is offered for transmission.
REQ-007 Port: data_ready  output  1  block can accept a word this cycle.
REQ-008 Port: serial_out  output  1  serial frame bitstream for a bitstream-to-word receiver.
REQ-009 Port: frame_sync  output  1  high during the cycle that carries data bit 0.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: frame_done  output  1  one-cycle pulse on the pad-bit cycle.
REQ-012 Port: overrun  output  1  sticky flag for a word offered while not ready.

Function
REQ-013 The state machine SHALL have the states IDLE, SHIFT, PAD and GAP.
REQ-014 data_ready SHALL equal (state==IDLE), decoded from the registered state only.
REQ-015 A transfer SHALL occur on an edge where data_valid && data_ready; data_in is captured into a DATA_W shift register.
REQ-016 Transitions: on a transfer, IDLE->SHIFT; after DATA_W cycles, SHIFT->PAD; after 1 cycle, PAD->GAP; after GAP_CYCLES cycles, GAP->IDLE.
REQ-017 With GAP_CYCLES==0, PAD SHALL go directly to IDLE.
REQ-018 Frame length SHALL be DATA_W+1 bit-times: data bits are sent LSB first, followed by one pad bit driven 0.
REQ-019 For a transfer on edge N, serial_out SHALL carry data bit k during cycle N+1+k, for k=0..DATA_W-1.
REQ-020 The pad bit SHALL appear at cycle N+1+DATA_W.
REQ-021 The GAP state SHALL cover cycles N+2+DATA_W .. N+1+DATA_W+GAP_CYCLES.
REQ-022 data_ready SHALL reassert at cycle N+2+DATA_W+GAP_CYCLES.
REQ-023 serial_out, frame_sync, frame_done and busy SHALL all be registered outputs, with no combinational path from inputs.
REQ-024 serial_out SHALL be 0 in IDLE, PAD and GAP.
REQ-025 frame_sync SHALL be high only at cycle N+1.
REQ-026 frame_done SHALL be high only at cycle N+1+DATA_W.
REQ-027 The shift register SHALL shift right once per SHIFT cycle, with serial_out taken from bit 0.
REQ-028 A changing data_in after capture SHALL NOT affect the frame in flight.
REQ-029 The bit counter SHALL be clog2(DATA_W+1) bits.
REQ-030 The gap counter SHALL be 17 bits, reset to 0 on PAD exit, with no wrap past GAP_CYCLES.
REQ-031 overrun SHALL set on any edge where data_valid==1 and data_ready==0; it is cleared only by reset.
REQ-032 overrun and a transfer SHALL NOT occur on the same edge.
REQ-033 Back-to-back operation: if data_valid is held high, the next transfer SHALL occur on the first cycle data_ready is high.
REQ-034 Back-to-back frame period SHALL be exactly DATA_W+2+GAP_CYCLES cycles.

Reset
REQ-035 When rst_n==0 at a rising edge, the following SHALL reset on that edge: state=IDLE, shift register=0, counters=0, serial_out=0, frame_sync=0, frame_done=0, busy=0, overrun=0.
REQ-036 data_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-037 Reset mid-frame (any state) SHALL abort the frame with no further data bits and no frame_done pulse.
REQ-038 A data_valid asserted while rst_n==0 SHALL be ignored and SHALL NOT set overrun.

Verification
REQ-039 Scenario, single frame: GAP_CYCLES=4, data_in=9'h1A5, valid for 1 cycle at edge N -> serial_out 1,0,1,0,0,1,0,1,1 on cycles N+1..N+9, 0 at N+10; frame_sync at N+1; frame_done at N+10; ready at N+15.
REQ-040 Scenario, back-to-back: GAP_CYCLES=4, valid held high with words 9'h000 then 9'h1FF -> second frame_sync exactly 15 cycles after the first; second frame bits all 1.
REQ-041 Scenario, zero gap: GAP_CYCLES=0, valid held high -> frame period 11 cycles; data_ready high for exactly one cycle per frame.
REQ-042 Scenario, overrun: valid asserted during GAP -> overrun=1 next cycle and stays 1; the following frame is unaffected; overrun clears only on reset.
REQ-043 Scenario, reset mid-frame: rst_n=0 at cycle N+5 of a frame -> serial_out=0 and busy=0 from N+6, no frame_done, data_ready=1 in the first cycle after release.
REQ-044 Scenario, loopback: default parameters, serial_out fed to the team's 9-bit bitstream receiver -> the receiver word equals data_in for values 0, 256 and 511.
